// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI target: oversamples CS/SCLK/MOSI in the aclk domain, decodes
// 16-bit commands and returns results two frames later on MISO (CPOL=0, CPHA=0).
module rhd_spi_responder #(
  parameter logic [7:0]  CHIP_ID     = 8'd1,
  parameter int unsigned MISO_DELAY  = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        frame_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_s, sclk_s, mosi_s;
  logic                   cs_fall, cs_rise, sclk_rise, sclk_fall;

  state_e      state_q, state_d;
  logic [15:0] rx_q, rx_d, tx_q, tx_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] res_q1, res_q1_d, res_q2, res_q2_d;
  logic [9:0]  conv_cnt_q, conv_cnt_d;
  logic [15:0] cmd_word_q, cmd_word_d;
  logic [7:0]  regs_q [32];

  logic        frame_ok, wr_en, miso_int;
  logic [5:0]  addr;
  logic [7:0]  rd_val;
  logic [15:0] result;
  logic        conv_inc, conv_clr, is_write;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(CS);
      sclk_sync_q <= (sclk_sync_q << 1) | SYNC_STAGES'(SCLK);
      mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(MOSI);
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign frame_ok  = (bit_cnt_q == 5'd16);
  assign addr      = rx_q[13:8];

  always_comb begin
    rd_val = 8'h00;
    if (!addr[5]) begin
      rd_val = regs_q[addr[4:0]];
    end else begin
      case (addr)
        6'd40:   rd_val = 8'h49;
        6'd41:   rd_val = 8'h4E;
        6'd42:   rd_val = 8'h54;
        6'd43:   rd_val = 8'h41;
        6'd44:   rd_val = 8'h4E;
        6'd63:   rd_val = CHIP_ID;
        default: rd_val = 8'h00;
      endcase
    end
  end

  // CALIBRATE and unknown patterns fall through with a zero result.
  always_comb begin
    result   = 16'h0000;
    conv_inc = 1'b0;
    conv_clr = 1'b0;
    is_write = 1'b0;
    case (rx_q[15:14])
      2'b00: if (rx_q[7:1] == 7'd0) begin
        result   = {rx_q[13:8], conv_cnt_q};
        conv_inc = 1'b1;
      end
      2'b01: conv_clr = (rx_q == 16'h6A00);
      2'b10: begin
        result   = {8'hFF, rx_q[7:0]};
        is_write = 1'b1;
      end
      default: result = {8'h00, rd_val};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    bit_cnt_d  = bit_cnt_q;
    res_q1_d   = res_q1;
    res_q2_d   = res_q2;
    conv_cnt_d = conv_cnt_q;
    cmd_word_d = cmd_word_q;
    wr_en      = 1'b0;
    case (state_q)
      ST_IDLE: if (cs_fall) begin
        state_d   = ST_SHIFT;
        tx_d      = res_q2;
        rx_d      = 16'h0000;
        bit_cnt_d = 5'd0;
      end
      ST_SHIFT: begin
        // A rising SCLK seen together with CS rising still counts toward this frame.
        if (sclk_rise) begin
          rx_d = {rx_q[14:0], mosi_s};
          if (bit_cnt_q != 5'd17) bit_cnt_d = bit_cnt_q + 5'd1;
        end
        if (sclk_fall) tx_d = {tx_q[14:0], 1'b0};
        if (cs_rise) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          res_q2_d   = res_q1;
          res_q1_d   = result;
          cmd_word_d = rx_q;
          wr_en      = is_write & ~addr[5];
          if (conv_clr) conv_cnt_d = 10'd0;
          else if (conv_inc) conv_cnt_d = conv_cnt_q + 10'd1;
        end
        // Back-to-back frame: the new frame must see the pipeline as just updated.
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          tx_d      = frame_ok ? res_q1 : res_q2;
          rx_d      = 16'h0000;
          bit_cnt_d = 5'd0;
        end
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      rx_q       <= '0;
      tx_q       <= '0;
      bit_cnt_q  <= '0;
      res_q1     <= '0;
      res_q2     <= '0;
      conv_cnt_q <= '0;
      cmd_word_q <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      bit_cnt_q  <= bit_cnt_d;
      res_q1     <= res_q1_d;
      res_q2     <= res_q2_d;
      conv_cnt_q <= conv_cnt_d;
      cmd_word_q <= cmd_word_d;
      if (wr_en) regs_q[addr[4:0]] <= rx_q[7:0];
    end
  end

  assign miso_int  = (state_q == ST_SHIFT) & ~cs_s & tx_q[15];
  assign cmd_valid = (state_q == ST_DONE) & frame_ok;
  assign frame_err = (state_q == ST_DONE) & ~frame_ok;
  assign cmd_word  = cmd_word_q;

  generate
    if (MISO_DELAY == 0) begin : g_no_dly
      assign MISO = miso_int;
    end else begin : g_dly
      logic [MISO_DELAY-1:0] dly_q;
      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) dly_q <= '0;
        else          dly_q <= (dly_q << 1) | MISO_DELAY'(miso_int);
      end
      assign MISO = dly_q[MISO_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Directed bench for rhd_spi_responder: a behavioural chip model predicts every
// MISO word and pulse count; a second instance with MISO_DELAY=3 is checked for lag.
module tb_rhd_spi_responder;
  localparam int H = 2;  // SCLK half-period in aclk cycles (master at aclk/4)

  logic        aclk = 1'b0, aresetn = 1'b0, CS = 1'b1, SCLK = 1'b0, MOSI = 1'b0;
  logic        miso0, cv0, fe0, miso3, cv3, fe3;
  logic [15:0] cw0, cw3;
  int          total = 0, bad = 0;

  always #5 aclk = ~aclk;

  rhd_spi_responder u_dut (
    .aclk(aclk), .aresetn(aresetn), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(miso0), .cmd_valid(cv0), .cmd_word(cw0), .frame_err(fe0)
  );

  rhd_spi_responder #(.MISO_DELAY(3)) u_dly (
    .aclk(aclk), .aresetn(aresetn), .CS(CS), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(miso3), .cmd_valid(cv3), .cmd_word(cw3), .frame_err(fe3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model of the chip ----------------
  logic [7:0]  m_regs [32];
  int          m_conv;
  logic [15:0] m_q1, m_q2, m_cmd;
  int          m_valid, m_err;

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
    m_conv = 0; m_q1 = 16'h0; m_q2 = 16'h0; m_cmd = 16'h0;
  endtask

  function automatic logic [7:0] m_read(input int r);
    if (r < 32) return m_regs[r];
    if (r == 40) return 8'h49;
    if (r == 41) return 8'h4E;
    if (r == 42) return 8'h54;
    if (r == 43) return 8'h41;
    if (r == 44) return 8'h4E;
    if (r == 63) return 8'h01;
    return 8'h00;
  endfunction

  task automatic m_apply(input logic [15:0] c);
    logic [15:0] r;
    int a;
    a = int'(c[13:8]);
    r = 16'h0000;
    if (c[15:14] == 2'b00 && c[7:1] == 7'd0) begin
      r = 16'(a * 1024 + m_conv);
      m_conv = (m_conv + 1) % 1024;
    end else if (c == 16'h6A00) begin
      m_conv = 0;
    end else if (c[15:14] == 2'b10) begin
      r = {8'hFF, c[7:0]};
      if (a < 32) m_regs[a] = c[7:0];
    end else if (c[15:14] == 2'b11) begin
      r = {8'h00, m_read(a)};
    end
    m_q2 = m_q1; m_q1 = r; m_cmd = c; m_valid++;
  endtask

  // ---------------- per-cycle compare process ----------------
  int   valid_seen = 0, err_seen = 0, cs_hi = 0, rst_hold = 4;
  logic hist [3] = '{1'b0, 1'b0, 1'b0};

  always @(negedge aclk) begin
    if (!aresetn) begin
      rst_hold = 4;
      cs_hi = 0;
    end else begin
      if (cv0) valid_seen++;
      if (fe0) err_seen++;
      if (rst_hold > 0) rst_hold--;
      else begin
        check("miso_lag3", {31'd0, miso3}, {31'd0, hist[2]});
        check("dly_inst_outs", {14'd0, cv3, fe3, cw3}, {14'd0, cv0, fe0, cw0});
        check("valid_err_excl", {31'd0, cv0 & fe0}, 32'd0);
      end
      cs_hi = CS ? cs_hi + 1 : 0;
      if (cs_hi >= 5) check("miso_cs_high", {31'd0, miso0}, 32'd0);
    end
    hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = miso0;
  end

  // ---------------- master stimulus ----------------
  // Drives one frame of nbits SCLK pulses; MISO is sampled just before each falling
  // edge (delay-compensated master). cs_last raises CS together with the last rise.
  task automatic do_frame(input logic [15:0] cmd, input int nbits, input bit cs_last,
                          input int gap, output logic [15:0] got);
    logic [31:0] cap, expw, mask;
    int ns;
    cap = 0; ns = 0;
    expw = {16'h0, m_q2};
    CS = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      repeat (H) @(negedge aclk);
      SCLK = 1'b1;
      if (cs_last && i == nbits - 1) begin
        CS = 1'b1;
      end else begin
        repeat (H) @(negedge aclk);
        cap = {cap[30:0], miso0};
        ns++;
      end
    end
    if (cs_last) begin
      @(negedge aclk);
      SCLK = 1'b0;
      repeat (gap - 1) @(negedge aclk);
    end else begin
      SCLK = 1'b0;
      repeat (H) @(negedge aclk);
      CS = 1'b1;
      repeat (gap) @(negedge aclk);
    end
    expw = (ns <= 16) ? (expw >> (16 - ns)) : (expw << (ns - 16));
    mask = (32'h1 << ns) - 32'h1;
    check($sformatf("miso_word cmd=%h bits=%0d", cmd, nbits), cap & mask, expw & mask);
    $display("frame cmd=%h bits=%0d miso=%h", cmd, nbits, cap[15:0]);
    got = cap[15:0];
    if (nbits == 16) m_apply(cmd);
    else m_err++;
  endtask

  task automatic group_end(input string name, input int v0, input int e0);
    repeat (8) @(negedge aclk);
    check({name, "_valid_cnt"}, 32'(valid_seen - v0), 32'(m_valid));
    check({name, "_err_cnt"}, 32'(err_seen - e0), 32'(m_err));
    check({name, "_cmd_word"}, {16'h0, cw0}, {16'h0, m_cmd});
    m_valid = 0; m_err = 0;
  endtask

  logic [15:0] w [6];
  int v0, e0;

  initial begin
    m_reset(); m_valid = 0; m_err = 0;
    repeat (4) @(negedge aclk);
    aresetn = 1'b1;
    repeat (4) @(negedge aclk);
    check("rst_miso", {31'd0, miso0}, 32'd0);
    check("rst_cmd_valid", {31'd0, cv0}, 32'd0);
    check("rst_frame_err", {31'd0, fe0}, 32'd0);
    check("rst_cmd_word", {16'd0, cw0}, 32'd0);

    // ROM reads
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'hE800, 16, 0, 8, w[0]);
    do_frame(16'hE900, 16, 0, 8, w[1]);
    do_frame(16'hFF00, 16, 0, 8, w[2]);
    do_frame(16'h0000, 16, 0, 8, w[3]);
    do_frame(16'h0000, 16, 0, 8, w[4]);
    check("rom_f3", {16'h0, w[2]}, 32'h0049);
    check("rom_f4", {16'h0, w[3]}, 32'h004E);
    check("rom_f5", {16'h0, w[4]}, 32'h0001);
    check("rom_pulses", 32'(valid_seen - v0), 32'd5);
    group_end("rom", v0, e0);

    // register write / read-back
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'h85A5, 16, 0, 8, w[0]);
    do_frame(16'hC500, 16, 0, 8, w[1]);
    do_frame(16'h0000, 16, 0, 8, w[2]);
    do_frame(16'h0000, 16, 0, 8, w[3]);
    check("wr_echo", {16'h0, w[2]}, 32'hFFA5);
    check("rd_back", {16'h0, w[3]}, 32'h00A5);
    group_end("wr", v0, e0);

    // conversions and counter clear
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'h6A00, 16, 0, 8, w[0]);
    for (int i = 1; i <= 3; i++) do_frame(16'h0200, 16, 0, 8, w[i]);
    do_frame(16'h0000, 16, 0, 8, w[4]);
    do_frame(16'h0000, 16, 0, 8, w[5]);
    check("conv_f3", {16'h0, w[3]}, 32'h0800);
    check("conv_f4", {16'h0, w[4]}, 32'h0801);
    check("conv_f5", {16'h0, w[5]}, 32'h0802);
    do_frame(16'h6A00, 16, 0, 8, w[0]);
    do_frame(16'h0001, 16, 0, 8, w[1]);
    do_frame(16'h5500, 16, 0, 8, w[2]);
    do_frame(16'h0000, 16, 0, 8, w[3]);
    check("clr_conv0", {16'h0, w[3]}, 32'h0000);
    group_end("conv", v0, e0);

    // malformed frames leave everything untouched (pipeline now holds 0x0000, 0x0001)
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'hFFFF, 15, 0, 8, w[0]);
    do_frame(16'h8155, 17, 0, 8, w[1]);
    do_frame(16'h0000, 16, 0, 8, w[2]);
    check("err_pipe_kept", {16'h0, w[2]}, 32'h0000);
    check("err_pulses", 32'(err_seen - e0), 32'd2);
    group_end("err", v0, e0);

    // timing boundaries: CS with last rise, CS re-fall in DONE, SCLK while CS high
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'hE800, 16, 1, 8, w[0]);
    do_frame(16'hE900, 16, 0, 1, w[1]);
    do_frame(16'hFF00, 16, 0, 8, w[2]);
    repeat (3) begin
      SCLK = 1'b1; repeat (2) @(negedge aclk);
      SCLK = 1'b0; repeat (2) @(negedge aclk);
    end
    do_frame(16'h0000, 16, 0, 8, w[3]);
    do_frame(16'h0000, 16, 0, 8, w[4]);
    check("bnd_f3", {16'h0, w[2]}, 32'h0049);
    check("bnd_f4", {16'h0, w[3]}, 32'h004E);
    check("bnd_f5", {16'h0, w[4]}, 32'h0001);
    group_end("bnd", v0, e0);

    // reset in the middle of WRITE reg 1 = 0x3C
    e0 = err_seen;
    CS = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0; MOSI = 1'(16'h813C >> (15 - i));
      repeat (H) @(negedge aclk);
      SCLK = 1'b1;
      repeat (H) @(negedge aclk);
    end
    aresetn = 1'b0;
    repeat (3) @(negedge aclk);
    CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    m_reset(); m_valid = 0; m_err = 0;
    repeat (4) @(negedge aclk);
    check("rst_no_err", 32'(err_seen - e0), 32'd0);
    check("rst_cmd_word_clr", {16'h0, cw0}, 32'h0000);
    v0 = valid_seen; e0 = err_seen;
    do_frame(16'hC100, 16, 0, 8, w[0]);
    do_frame(16'h0000, 16, 0, 8, w[1]);
    do_frame(16'h0000, 16, 0, 8, w[2]);
    check("rst_miso_f1", {16'h0, w[0]}, 32'h0000);
    check("rst_reg1", {16'h0, w[2]}, 32'h0000);
    group_end("rst", v0, e0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rhd_spi_responder.md
Name: rhd_spi_responder

Overview:
- Synthesizable RHD2000-style SPI target model: the chip end of the headstage SPI link.
- Receives 16-bit command frames on CS/SCLK/MOSI and returns pipelined results on MISO.
- Used in block-design testbenches and loopback builds to close the loop for the RHD acquisition master, including MISO delay compensation.
- Oversamples the SPI pins in the aclk domain; aclk ≥ 4× SCLK.

Parameters:
CHIP_ID, 1, 8-bit value returned for ROM register 63.
MISO_DELAY, 0, extra aclk cycles (0..15) inserted on MISO to emulate cable/isolator delay.
SYNC_STAGES, 2, synchronizer depth for CS, SCLK and MOSI (≥ 2).

Ports:
aclk  in  1  system clock; all logic on rising edge.
aresetn  in  1  asynchronous active-low reset.
CS  in  1  active-low frame select from master.
SCLK  in  1  SPI clock, idle low (CPOL=0).
MOSI  in  1  command data, MSB first.
MISO  out  1  result data, MSB first.
cmd_valid  out  1  one-cycle pulse when a valid frame is accepted.
cmd_word  out  16  last accepted command; held until the next accepted frame.
frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Interface: one clock, aclk; reset aresetn is asynchronous, active-low.
- Reset values:
  - MISO = 0, cmd_valid = 0, cmd_word = 0, frame_err = 0.
  - Result pipeline stages res_q1 = res_q2 = 0.
  - conv_cnt = 0; writable register file regs 0..31 = 0.
- Input sampling:
  - CS, SCLK and MOSI pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized signals only.
- States:
  - IDLE: synced CS high. Transition to SHIFT on a CS falling edge.
  - SHIFT: on each synced SCLK rising edge, shift synced MOSI into the 16-bit rx register and increment bit_cnt (5-bit, saturates at 17). Transition to DONE on a CS rising edge.
  - DONE (1 cycle): bit_cnt == 16 means valid; otherwise it is an error. Return to IDLE.
- MISO (CPHA=0):
  - On the CS falling edge, tx register <= res_q2 and MISO drives bit 15 immediately.
  - On each synced SCLK falling edge in SHIFT, shift left; MISO = next bit.
  - After 16 bits, and whenever CS is high, MISO = 0.
  - MISO_DELAY > 0: the internal MISO passes through a MISO_DELAY-deep shift register, reset to 0.
- Command decode, on a valid frame only:
  - CONVERT 00cccccc_0000000h: result = {c[5:0], conv_cnt[9:0]}; conv_cnt += 1, wrapping 1023 -> 0. The h bit is ignored.
  - CALIBRATE 0x5500: result = 0x0000.
  - CLEAR 0x6A00: result = 0x0000; conv_cnt <= 0.
  - WRITE 10rrrrrr_dddddddd: result = {8'hFF, d}. If r < 32, reg[r] <= d; otherwise no write.
  - READ 11rrrrrr_xxxxxxxx: result = {8'h00, v}, where:
    - v = reg[r] for r < 32.
    - Regs 40..44 = "I","N","T","A","N" (0x49, 0x4E, 0x54, 0x41, 0x4E).
    - Reg 63 = CHIP_ID.
    - All other registers = 0.
  - Any other pattern: result = 0x0000, and the frame still counts as valid.
- Pipeline:
  - On a valid DONE: res_q2 <= res_q1, res_q1 <= result.
  - The result of frame N therefore appears on MISO during frame N+2.
  - cmd_word <= rx; cmd_valid pulses for the DONE cycle.
- Error frame (bit_cnt ≠ 16, including 0 edges or >16 edges):
  - No decode, no register write, pipeline unchanged, conv_cnt unchanged.
  - frame_err pulses.
- Boundary cases:
  - CS rising in the same cycle as the 16th SCLK rising edge: the edge is counted first, so the frame is valid.
  - CS falling in the same cycle as DONE: DONE completes first, then the next frame enters SHIFT with the updated res_q2.
  - SCLK edges while CS is high are ignored.
  - aresetn asserted mid-frame: immediate return to IDLE with all reset values. The partial frame is discarded without frame_err.

Test Plan:
- Reset, then READ 40, READ 41, READ 63, then 2 dummy 0x0000 frames -> MISO words in frames 3..5 = 0x0049, 0x004E, 0x0001; cmd_valid 5 pulses.
- WRITE reg 5 = 0xA5 (0x85A5), READ 5 (0xC500), 2 dummies -> frame-3 MISO = 0xFFA5, frame-4 MISO = 0x00A5.
- 3× CONVERT ch 2 (0x0200) + 2 dummies -> frame-3..5 MISO = 0x0800, 0x0801, 0x0802; CLEAR, then CONVERT ch 0 -> result 0x0000.
- Frame with 15 SCLK edges, then one with 17 -> frame_err pulses twice, no cmd_valid; the next valid frame's MISO equals the pre-error pipeline value.
- MISO_DELAY=3, master at aclk/4 -> MISO transitions lag the undelayed build by exactly 3 aclk cycles; data identical.
- aresetn pulsed after 8 bits of a WRITE reg 1 = 0x3C -> reg 1 reads 0x00, no frame_err, and MISO = 0 during the following frame.
